// File: rtl/bp_txn_master.sv
// bp_txn_master: host-side BytePipe transaction master.
// Ports: clk/rstn/cg, req (valid/ready/wr/addr/data), rsp (valid/ready/data/timeout), bp out/in, stray.
module bp_txn_master #(
  parameter int TIMEOUT = 255
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_cg,
  input  logic       i_req_valid,
  output logic       o_req_ready,
  input  logic       i_req_wr,
  input  logic [6:0] i_req_addr,
  input  logic [7:0] i_req_data,
  output logic       o_rsp_valid,
  input  logic       i_rsp_ready,
  output logic [7:0] o_rsp_data,
  output logic       o_rsp_timeout,
  output logic [7:0] o_bp_data,
  output logic       o_bp_valid,
  input  logic       i_bp_ready,
  input  logic [7:0] i_bp_data,
  input  logic       i_bp_valid,
  output logic       o_bp_ready,
  output logic       o_stray
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_DATA,
    S_WAIT,
    S_RSP
  } state_e;

  state_e        state_q, state_d;
  logic          wr_q, wr_d;
  logic [6:0]    addr_q, addr_d;
  logic [7:0]    data_q, data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    rsp_q, rsp_d;
  logic          to_q, to_d;
  logic          stray_q, stray_d;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= S_IDLE;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      rsp_q   <= '0;
      to_q    <= 1'b0;
      stray_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      rsp_q   <= rsp_d;
      to_q    <= to_d;
      stray_q <= stray_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    rsp_d   = rsp_q;
    to_d    = to_q;
    stray_d = stray_q;
    // Everything freezes while the clock gate is low.
    if (i_cg) begin
      unique case (state_q)
        S_IDLE: begin
          if (i_req_valid) begin
            wr_d    = i_req_wr;
            addr_d  = i_req_addr;
            data_d  = i_req_data;
            state_d = S_CMD;
          end
        end
        S_CMD: begin
          cnt_d = '0;
          if (i_bp_ready) begin
            state_d = wr_q ? S_DATA : S_WAIT;
          end
        end
        S_DATA: begin
          cnt_d = '0;
          if (i_bp_ready) begin
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          cnt_d = cnt_q + CW'(1);
          // A byte in the expiry cycle takes priority over the timeout.
          if (i_bp_valid) begin
            rsp_d   = i_bp_data;
            to_d    = 1'b0;
            state_d = S_RSP;
          end else if (cnt_q == CNT_LAST) begin
            rsp_d   = 8'h00;
            to_d    = 1'b1;
            state_d = S_RSP;
          end
        end
        S_RSP: begin
          if (i_rsp_ready) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
      if (i_bp_valid && (state_q != S_WAIT)) begin
        stray_d = 1'b1;
      end
    end
  end

  always_comb begin
    o_bp_data = 8'h00;
    unique case (state_q)
      S_CMD:   o_bp_data = {wr_q, addr_q};
      S_DATA:  o_bp_data = data_q;
      default: o_bp_data = 8'h00;
    endcase
  end

  assign o_bp_valid    = (state_q == S_CMD) || (state_q == S_DATA);
  assign o_rsp_valid   = (state_q == S_RSP);
  assign o_req_ready   = i_cg && (state_q == S_IDLE);
  assign o_bp_ready    = i_cg;
  assign o_rsp_data    = rsp_q;
  assign o_rsp_timeout = to_q;
  assign o_stray       = stray_q;

endmodule

// File: tb/tb_bp_txn_master.sv
// tb_bp_txn_master: directed + random transactions against a
// behavioural BytePipe slave and cycle-latency model.
module tb_bp_txn_master;

  localparam int TO = 8;

  logic       i_clk = 1'b0;
  logic       i_rstn;
  logic       i_cg;
  logic       i_req_valid;
  logic       o_req_ready;
  logic       i_req_wr;
  logic [6:0] i_req_addr;
  logic [7:0] i_req_data;
  logic       o_rsp_valid;
  logic       i_rsp_ready;
  logic [7:0] o_rsp_data;
  logic       o_rsp_timeout;
  logic [7:0] o_bp_data;
  logic       o_bp_valid;
  logic       i_bp_ready;
  logic [7:0] i_bp_data;
  logic       i_bp_valid;
  logic       o_bp_ready;
  logic       o_stray;

  bp_txn_master #(.TIMEOUT(TO)) dut (
    .i_clk(i_clk),
    .i_rstn(i_rstn),
    .i_cg(i_cg),
    .i_req_valid(i_req_valid),
    .o_req_ready(o_req_ready),
    .i_req_wr(i_req_wr),
    .i_req_addr(i_req_addr),
    .i_req_data(i_req_data),
    .o_rsp_valid(o_rsp_valid),
    .i_rsp_ready(i_rsp_ready),
    .o_rsp_data(o_rsp_data),
    .o_rsp_timeout(o_rsp_timeout),
    .o_bp_data(o_bp_data),
    .o_bp_valid(o_bp_valid),
    .i_bp_ready(i_bp_ready),
    .i_bp_data(i_bp_data),
    .i_bp_valid(i_bp_valid),
    .o_bp_ready(o_bp_ready),
    .o_stray(o_stray)
  );

  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] mem [128];
  logic [6:0] prev_addr;

  task automatic tick();
    @(posedge i_clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic slave_reset();
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    prev_addr = 7'h00;
  endtask

  // Write returns old value at addr; read returns value at previous addr.
  task automatic slave_model(input logic wr, input logic [6:0] a,
                             input logic [7:0] d, output logic [7:0] r);
    if (wr) begin
      r = mem[a];
      mem[a] = d;
    end else begin
      r = mem[prev_addr];
    end
    prev_addr = a;
  endtask

  // lat < 0: slave silent. ovr >= 0: slave sends this byte instead.
  task automatic txn(input logic wr, input logic [6:0] a,
                     input logic [7:0] d, input int stall,
                     input int lat, input int rsp_stall,
                     input int gate, input int ovr);
    logic [7:0] b [$];
    logic [7:0] rsp;
    int acc;
    int expl;
    int n;
    slave_model(wr, a, d, rsp);
    if (ovr >= 0) rsp = ovr[7:0];
    b.push_back({wr, a});
    if (wr) b.push_back(d);
    chk("req_ready_idle", {31'd0, o_req_ready}, 32'd1);
    i_req_valid = 1'b1;
    i_req_wr    = wr;
    i_req_addr  = a;
    i_req_data  = d;
    acc = cyc;
    tick();
    i_req_valid = 1'b0;
    i_req_data  = 8'($urandom);
    expl = 1;
    foreach (b[k]) begin
      for (int s = 0; s < stall; s++) begin
        i_bp_ready = 1'b0;
        chk("bp_valid_stall", {31'd0, o_bp_valid}, 32'd1);
        chk("bp_data_stall", {24'd0, o_bp_data}, {24'd0, b[k]});
        tick();
        expl++;
      end
      if (k == 1 && gate > 0) begin
        i_cg = 1'b0;
        i_bp_ready = 1'b1;
        #1;
        for (int g = 0; g < gate; g++) begin
          chk("gate_req_ready", {31'd0, o_req_ready}, 32'd0);
          chk("gate_bp_ready", {31'd0, o_bp_ready}, 32'd0);
          chk("gate_bp_valid", {31'd0, o_bp_valid}, 32'd1);
          chk("gate_bp_data", {24'd0, o_bp_data}, {24'd0, b[k]});
          tick();
          expl++;
        end
        i_cg = 1'b1;
      end
      i_bp_ready = 1'b1;
      chk("bp_valid", {31'd0, o_bp_valid}, 32'd1);
      chk("bp_data", {24'd0, o_bp_data}, {24'd0, b[k]});
      tick();
      expl++;
      i_bp_ready = 1'b0;
    end
    chk("bp_valid_wait", {31'd0, o_bp_valid}, 32'd0);
    if (lat >= 0) begin
      for (int l = 0; l < lat; l++) begin
        chk("rsp_early", {31'd0, o_rsp_valid}, 32'd0);
        tick();
        expl++;
      end
      i_bp_valid = 1'b1;
      i_bp_data  = rsp;
      tick();
      expl++;
      i_bp_valid = 1'b0;
      i_bp_data  = 8'($urandom);
    end else begin
      n = 0;
      while (!o_rsp_valid && n < 4 * TO) begin
        tick();
        n++;
      end
      expl += TO;
      rsp = 8'h00;
    end
    chk("rsp_latency", cyc - acc, expl);
    chk("rsp_valid", {31'd0, o_rsp_valid}, 32'd1);
    chk("rsp_data", {24'd0, o_rsp_data}, {24'd0, rsp});
    chk("rsp_timeout", {31'd0, o_rsp_timeout}, (lat < 0) ? 32'd1 : 32'd0);
    for (int r = 0; r < rsp_stall; r++) begin
      i_rsp_ready = 1'b0;
      chk("rsp_hold_valid", {31'd0, o_rsp_valid}, 32'd1);
      chk("rsp_hold_data", {24'd0, o_rsp_data}, {24'd0, rsp});
      chk("rsp_hold_reqrdy", {31'd0, o_req_ready}, 32'd0);
      tick();
    end
    i_rsp_ready = 1'b1;
    tick();
    i_rsp_ready = 1'b0;
    chk("rsp_done", {31'd0, o_rsp_valid}, 32'd0);
    chk("back_idle", {31'd0, o_req_ready}, 32'd1);
  endtask

  initial begin
    i_rstn      = 1'b0;
    i_cg        = 1'b1;
    i_req_valid = 1'b0;
    i_req_wr    = 1'b0;
    i_req_addr  = '0;
    i_req_data  = '0;
    i_rsp_ready = 1'b0;
    i_bp_ready  = 1'b0;
    i_bp_data   = '0;
    i_bp_valid  = 1'b0;
    slave_reset();
    #1;
    chk("rst_bp_valid", {31'd0, o_bp_valid}, 32'd0);
    chk("rst_bp_data", {24'd0, o_bp_data}, 32'd0);
    chk("rst_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
    chk("rst_rsp_data", {24'd0, o_rsp_data}, 32'd0);
    chk("rst_rsp_to", {31'd0, o_rsp_timeout}, 32'd0);
    chk("rst_stray", {31'd0, o_stray}, 32'd0);
    chk("rst_req_ready", {31'd0, o_req_ready}, 32'd1);
    chk("rst_bp_ready", {31'd0, o_bp_ready}, 32'd1);
    #20;
    @(negedge i_clk);
    i_rstn = 1'b1;
    tick();

    txn(1'b1, 7'h05, 8'hA5, 0, 0, 0, 0, -1);
    txn(1'b0, 7'h05, 8'h00, 0, 0, 0, 0, -1);
    txn(1'b1, 7'h05, 8'h11, 4, 1, 3, 0, -1);
    txn(1'b1, 7'h10, 8'h77, 0, 1, 0, 5, -1);
    txn(1'b0, 7'h10, 8'h00, 0, TO - 1, 0, 0, 8'h3C);
    chk("race_no_stray", {31'd0, o_stray}, 32'd0);
    txn(1'b0, 7'h03, 8'h00, 0, -1, 0, 0, -1);
    chk("pre_stray", {31'd0, o_stray}, 32'd0);
    i_bp_valid = 1'b1;
    i_bp_data  = 8'h99;
    tick();
    i_bp_valid = 1'b0;
    chk("late_stray", {31'd0, o_stray}, 32'd1);
    chk("late_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
    chk("late_req_ready", {31'd0, o_req_ready}, 32'd1);

    for (int i = 0; i < 20; i++) begin
      txn(1'($urandom), 7'($urandom), 8'($urandom),
          int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
          int'($urandom_range(0, 2)), 0, -1);
    end

    // Abandon a read in WAIT via asynchronous reset.
    i_req_valid = 1'b1;
    i_req_wr    = 1'b0;
    i_req_addr  = 7'h22;
    tick();
    i_req_valid = 1'b0;
    i_bp_ready  = 1'b1;
    tick();
    i_bp_ready  = 1'b0;
    tick();
    #2;
    i_rstn = 1'b0;
    #1;
    chk("arst_bp_valid", {31'd0, o_bp_valid}, 32'd0);
    chk("arst_bp_data", {24'd0, o_bp_data}, 32'd0);
    chk("arst_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
    chk("arst_rsp_data", {24'd0, o_rsp_data}, 32'd0);
    chk("arst_rsp_to", {31'd0, o_rsp_timeout}, 32'd0);
    chk("arst_stray", {31'd0, o_stray}, 32'd0);
    chk("arst_req_ready", {31'd0, o_req_ready}, 32'd1);
    slave_reset();
    @(negedge i_clk);
    i_rstn = 1'b1;
    tick();
    txn(1'b1, 7'h22, 8'h5C, 0, 0, 0, 0, -1);
    txn(1'b0, 7'h22, 8'h00, 1, 2, 1, 0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
